// File: rtl/thermo_pkg.sv
// Shared constants, state encoding and a counter helper for the thermometer-code decoder.
package thermo_pkg;

    localparam int CODE_W = 8;

    localparam logic [CODE_W-1:0] T_BELOW = 8'd18;
    localparam logic [CODE_W-1:0] T_MIN   = 8'd19;
    localparam logic [CODE_W-1:0] T_MAX   = 8'd26;
    localparam logic [CODE_W-1:0] T_ABOVE = 8'd27;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Saturating increment of the stability counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
        logic [3:0] res;
        if (cnt >= lim) begin
            res = lim;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/thermo_code_check.sv
// Combinational legality check and decode of one (bar code, alert) sample.
module thermo_code_check
    import thermo_pkg::*;
(
    input  logic [CODE_W-1:0] coded_i,
    input  logic              alert_i,
    output logic              legal,
    output logic [CODE_W-1:0] temp
);

    // Decode: alert words only allow the two out-of-range markers.
    always_comb begin
        legal = 1'b0;
        temp  = 8'd0;
        if (alert_i) begin
            case (coded_i)
                8'h01:   begin legal = 1'b1; temp = T_BELOW; end
                8'hFF:   begin legal = 1'b1; temp = T_ABOVE; end
                default: begin legal = 1'b0; temp = 8'd0;    end
            endcase
        end else begin
            case (coded_i)
                8'h01:   begin legal = 1'b1; temp = T_MIN;         end
                8'h03:   begin legal = 1'b1; temp = T_MIN + 8'd1;  end
                8'h07:   begin legal = 1'b1; temp = T_MIN + 8'd2;  end
                8'h0F:   begin legal = 1'b1; temp = T_MIN + 8'd3;  end
                8'h1F:   begin legal = 1'b1; temp = T_MIN + 8'd4;  end
                8'h3F:   begin legal = 1'b1; temp = T_MIN + 8'd5;  end
                8'h7F:   begin legal = 1'b1; temp = T_MIN + 8'd6;  end
                8'hFF:   begin legal = 1'b1; temp = T_MAX;         end
                default: begin legal = 1'b0; temp = 8'd0;          end
            endcase
        end
    end

endmodule

// File: rtl/thermo_code_decoder.sv
// Debouncing receiver for thermometer-coded temperature with valid/ready publication.
// Optional min/max tracking of published temperatures is enabled by THERMO_DEC_MINMAX_EN.
module thermo_code_decoder
    import thermo_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CODE_W-1:0] coded_i,
    input  logic              alert_i,
    input  logic              sample_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [CODE_W-1:0] temp_o,
    output logic              alert_o,
    input  logic              clr_err_i,
    output logic              code_err_o,
    output logic [7:0]        alert_cnt_o,
    output logic [CODE_W-1:0] min_temp_o,
    output logic [CODE_W-1:0] max_temp_o
);

    localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYCLES);

    logic              chk_legal_s;
    logic [CODE_W-1:0] chk_temp_s;

    state_t            state_r,      state_s;
    logic [CODE_W-1:0] cand_r,       cand_s;
    logic [3:0]        count_r,      count_s;
    logic              last_valid_r, last_valid_s;
    logic [CODE_W-1:0] last_temp_r,  last_temp_s;
    logic              valid_r,      valid_s;
    logic [CODE_W-1:0] temp_r,       temp_s;
    logic              alert_r,      alert_s;
    logic              code_err_r,   code_err_s;
    logic [7:0]        alert_cnt_r,  alert_cnt_s;
    logic              accept_s;
    logic              is_new_s;

    thermo_code_check u_check (
        .coded_i (coded_i),
        .alert_i (alert_i),
        .legal   (chk_legal_s),
        .temp    (chk_temp_s)
    );

    assign accept_s = valid_r & ready_i;
    // A legal sample always equals the candidate it produces, so compare the sample itself.
    assign is_new_s = ~last_valid_r | (chk_temp_s != last_temp_r);

    // Next-state and output logic of the debounce/publish FSM.
    always_comb begin
        state_s      = state_r;
        cand_s       = cand_r;
        count_s      = count_r;
        last_valid_s = last_valid_r;
        last_temp_s  = last_temp_r;
        valid_s      = valid_r;
        temp_s       = temp_r;
        alert_s      = alert_r;
        alert_cnt_s  = alert_cnt_r;
        if (clr_err_i) begin
            code_err_s = 1'b0;
        end else begin
            code_err_s = code_err_r;
        end

        case (state_r)
            IDLE, TRACK: begin
                if (sample_i && chk_legal_s) begin
                    if ((state_r == TRACK) && (chk_temp_s == cand_r)) begin
                        count_s = sat_inc(count_r, STABLE_LIM);
                    end else begin
                        cand_s  = chk_temp_s;
                        count_s = 4'd1;
                    end
                    if ((count_s == STABLE_LIM) && is_new_s) begin
                        state_s = HOLD;
                        valid_s = 1'b1;
                        temp_s  = chk_temp_s;
                        alert_s = alert_i;
                    end else begin
                        state_s = TRACK;
                    end
                end else if (sample_i) begin
                    // An illegal code wins over a simultaneous clear.
                    code_err_s = 1'b1;
                    cand_s     = 8'd0;
                    count_s    = 4'd0;
                    state_s    = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            HOLD: begin
                if (accept_s) begin
                    state_s      = TRACK;
                    valid_s      = 1'b0;
                    last_valid_s = 1'b1;
                    last_temp_s  = temp_r;
                    if (alert_r && (alert_cnt_r != 8'hFF)) begin
                        alert_cnt_s = alert_cnt_r + 8'd1;
                    end else begin
                        alert_cnt_s = alert_cnt_r;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            cand_r       <= 8'd0;
            count_r      <= 4'd0;
            last_valid_r <= 1'b0;
            last_temp_r  <= 8'd0;
            valid_r      <= 1'b0;
            temp_r       <= 8'd0;
            alert_r      <= 1'b0;
            code_err_r   <= 1'b0;
            alert_cnt_r  <= 8'd0;
        end else begin
            state_r      <= state_s;
            cand_r       <= cand_s;
            count_r      <= count_s;
            last_valid_r <= last_valid_s;
            last_temp_r  <= last_temp_s;
            valid_r      <= valid_s;
            temp_r       <= temp_s;
            alert_r      <= alert_s;
            code_err_r   <= code_err_s;
            alert_cnt_r  <= alert_cnt_s;
        end
    end

    assign valid_o     = valid_r;
    assign temp_o      = temp_r;
    assign alert_o     = alert_r;
    assign code_err_o  = code_err_r;
    assign alert_cnt_o = alert_cnt_r;

`ifdef THERMO_DEC_MINMAX_EN
    logic [CODE_W-1:0] min_r;
    logic [CODE_W-1:0] max_r;

    // Extremes of accepted words; the first accept after reset loads both directly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            min_r <= 8'hFF;
            max_r <= 8'h00;
        end else if (accept_s) begin
            if (!last_valid_r || (temp_r < min_r)) begin
                min_r <= temp_r;
            end else begin
                min_r <= min_r;
            end
            if (!last_valid_r || (temp_r > max_r)) begin
                max_r <= temp_r;
            end else begin
                max_r <= max_r;
            end
        end else begin
            min_r <= min_r;
            max_r <= max_r;
        end
    end

    assign min_temp_o = min_r;
    assign max_temp_o = max_r;
`else
    assign min_temp_o = 8'h00;
    assign max_temp_o = 8'h00;
`endif

endmodule

// File: tb/tb_thermo_code_decoder.sv
// Directed self-checking bench: decode table on the checker, then multi-cycle sequences on the top.
module tb_thermo_code_decoder;
    import thermo_pkg::*;

`ifdef THERMO_DEC_MINMAX_EN
    localparam logic [7:0] EXP_MIN_RST = 8'hFF;
    localparam logic [7:0] EXP_MIN_T3  = 8'd18;
    localparam logic [7:0] EXP_MAX_T3  = 8'd27;
`else
    localparam logic [7:0] EXP_MIN_RST = 8'h00;
    localparam logic [7:0] EXP_MIN_T3  = 8'h00;
    localparam logic [7:0] EXP_MAX_T3  = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] coded = 8'd0;
    logic       alert = 1'b0;
    logic       sample = 1'b0;
    logic       ready = 1'b0;
    logic       clr_err = 1'b0;
    logic       valid;
    logic [7:0] temp;
    logic       alert_out;
    logic       code_err;
    logic [7:0] alert_cnt;
    logic [7:0] min_temp;
    logic [7:0] max_temp;

    logic [7:0] ref_code = 8'd0;
    logic       ref_alert = 1'b0;
    logic       ref_legal;
    logic [7:0] ref_temp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    thermo_code_decoder #(.STABLE_CYCLES(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .coded_i     (coded),
        .alert_i     (alert),
        .sample_i    (sample),
        .ready_i     (ready),
        .valid_o     (valid),
        .temp_o      (temp),
        .alert_o     (alert_out),
        .clr_err_i   (clr_err),
        .code_err_o  (code_err),
        .alert_cnt_o (alert_cnt),
        .min_temp_o  (min_temp),
        .max_temp_o  (max_temp)
    );

    thermo_code_check u_ref (
        .coded_i (ref_code),
        .alert_i (ref_alert),
        .legal   (ref_legal),
        .temp    (ref_temp)
    );

    typedef struct {
        logic [7:0] code;
        logic       alrt;
        logic       legal;
        logic [7:0] tmp;
    } dec_vec_t;

    dec_vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] c, input logic a, input logic s, input logic r);
        coded  = c;
        alert  = a;
        sample = s;
        ready  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"},     32'(valid),     32'd0);
        chk({tag, "_temp"},      32'(temp),      32'd0);
        chk({tag, "_alert"},     32'(alert_out), 32'd0);
        chk({tag, "_err"},       32'(code_err),  32'd0);
        chk({tag, "_alert_cnt"}, 32'(alert_cnt), 32'd0);
        chk({tag, "_min"},       32'(min_temp),  32'(EXP_MIN_RST));
        chk({tag, "_max"},       32'(max_temp),  32'd0);
    endtask

    // Publish one code stably: three quiet samples, then the publishing fourth.
    task automatic publish(input string tag, input logic [7:0] c, input logic a,
                           input logic [7:0] exp_t);
        for (int i = 0; i < 3; i++) begin
            step(c, a, 1'b1, 1'b0);
            chk({tag, "_early_valid"}, 32'(valid), 32'd0);
        end
        step(c, a, 1'b1, 1'b0);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_temp"},  32'(temp),  32'(exp_t));
        chk({tag, "_alert"}, 32'(alert_out), 32'(a));
    endtask

    initial begin
        vecs[0]  = '{8'h01, 1'b0, 1'b1, 8'd19};
        vecs[1]  = '{8'h03, 1'b0, 1'b1, 8'd20};
        vecs[2]  = '{8'h07, 1'b0, 1'b1, 8'd21};
        vecs[3]  = '{8'h0F, 1'b0, 1'b1, 8'd22};
        vecs[4]  = '{8'h1F, 1'b0, 1'b1, 8'd23};
        vecs[5]  = '{8'h3F, 1'b0, 1'b1, 8'd24};
        vecs[6]  = '{8'h7F, 1'b0, 1'b1, 8'd25};
        vecs[7]  = '{8'hFF, 1'b0, 1'b1, 8'd26};
        vecs[8]  = '{8'h01, 1'b1, 1'b1, 8'd18};
        vecs[9]  = '{8'hFF, 1'b1, 1'b1, 8'd27};
        vecs[10] = '{8'h00, 1'b0, 1'b0, 8'd0};
        vecs[11] = '{8'h05, 1'b0, 1'b0, 8'd0};
        vecs[12] = '{8'h07, 1'b1, 1'b0, 8'd0};
        vecs[13] = '{8'h00, 1'b1, 1'b0, 8'd0};
        vecs[14] = '{8'h80, 1'b0, 1'b0, 8'd0};
        vecs[15] = '{8'hFE, 1'b0, 1'b0, 8'd0};

        for (int i = 0; i < 16; i++) begin
            ref_code  = vecs[i].code;
            ref_alert = vecs[i].alrt;
            #1;
            chk($sformatf("dec_legal_%0d", i), 32'(ref_legal), 32'(vecs[i].legal));
            if (vecs[i].legal) begin
                chk($sformatf("dec_temp_%0d", i), 32'(ref_temp), 32'(vecs[i].tmp));
            end else begin
                chk($sformatf("dec_illegal_nonzero_%0d", i), 32'(ref_legal), 32'd0);
            end
        end

        // Reset
        rst = 1'b1;
        step(8'h00, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check_reset_values("rst");

        // T1: 0F with a sample_i=0 gap carrying an illegal code, which must be ignored
        step(8'h0F, 1'b0, 1'b1, 1'b0);
        step(8'h0F, 1'b0, 1'b1, 1'b0);
        step(8'h05, 1'b0, 1'b0, 1'b0);
        chk("t1_gap_err", 32'(code_err), 32'd0);
        chk("t1_gap_valid", 32'(valid), 32'd0);
        step(8'h0F, 1'b0, 1'b1, 1'b0);
        chk("t1_third_valid", 32'(valid), 32'd0);
        step(8'h0F, 1'b0, 1'b1, 1'b0);
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_temp", 32'(temp), 32'd22);
        chk("t1_alert", 32'(alert_out), 32'd0);
        step(8'h0F, 1'b0, 1'b1, 1'b0);
        chk("t1_still_valid", 32'(valid), 32'd1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("t1_accept_valid", 32'(valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(8'h0F, 1'b0, 1'b1, 1'b0);
            chk("t1_no_republish", 32'(valid), 32'd0);
        end

        // T2: short 0F run then 1F x4 gives a single publication of 23
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(8'h0F, 1'b0, 1'b1, 1'b0);
            chk("t2_0f_valid", 32'(valid), 32'd0);
        end
        publish("t2", 8'h1F, 1'b0, 8'd23);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("t2_accept_valid", 32'(valid), 32'd0);

        // T3: alert words 18 then 27
        publish("t3a", 8'h01, 1'b1, 8'd18);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("t3a_cnt", 32'(alert_cnt), 32'd1);
        publish("t3b", 8'hFF, 1'b1, 8'd27);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("t3b_cnt", 32'(alert_cnt), 32'd2);
        chk("t3_min", 32'(min_temp), 32'(EXP_MIN_T3));
        chk("t3_max", 32'(max_temp), 32'(EXP_MAX_T3));

        // T4: illegal codes and clear priority
        step(8'h05, 1'b0, 1'b1, 1'b0);
        chk("t4_err_05", 32'(code_err), 32'd1);
        chk("t4_valid_05", 32'(valid), 32'd0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("t4_err_sticky", 32'(code_err), 32'd1);
        clr_err = 1'b1;
        step(8'h00, 1'b0, 1'b0, 1'b0);
        clr_err = 1'b0;
        chk("t4_err_cleared", 32'(code_err), 32'd0);
        step(8'h07, 1'b1, 1'b1, 1'b0);
        chk("t4_err_07a", 32'(code_err), 32'd1);
        clr_err = 1'b1;
        step(8'h00, 1'b0, 1'b1, 1'b0);
        chk("t4_set_wins", 32'(code_err), 32'd1);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        clr_err = 1'b0;
        chk("t4_err_cleared2", 32'(code_err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(8'hFF, 1'b1, 1'b1, 1'b0);
            chk("t4_last_kept_no_pub", 32'(valid), 32'd0);
        end

        // T5: HOLD freezes the word and ignores samples for 10 stalled cycles
        publish("t5", 8'h3F, 1'b0, 8'd24);
        for (int i = 0; i < 10; i++) begin
            step(8'(i * 37 + 1), 1'(i), 1'b1, 1'b0);
            chk("t5_hold_valid", 32'(valid), 32'd1);
            chk("t5_hold_temp", 32'(temp), 32'd24);
            chk("t5_hold_err", 32'(code_err), 32'd0);
        end
        step(8'h3F, 1'b0, 1'b1, 1'b1);
        chk("t5_accept_valid", 32'(valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(8'h3F, 1'b0, 1'b1, 1'b0);
            chk("t5_no_republish", 32'(valid), 32'd0);
        end

        // T6: reset mid-HOLD, then the same code republishes
        publish("t6a", 8'h7F, 1'b0, 8'd25);
        rst = 1'b1;
        step(8'h7F, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        check_reset_values("t6_rst");
        publish("t6b", 8'h7F, 1'b0, 8'd25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
